// File: rtl/spdif_pkg.sv
// Shared definitions for the S/PDIF transmitter: preambles, framing constants, channel status.
// Latency: n/a (package).
// Backpressure: n/a (package).
package spdif_pkg;

   // Preamble half-cell patterns, MSB is transmitted first. All of them end low.
   localparam logic [7:0] PRE_B = 8'b11101000;   // left subframe, frame 0 of a block
   localparam logic [7:0] PRE_M = 8'b11100010;   // left subframe, other frames
   localparam logic [7:0] PRE_W = 8'b11100100;   // right subframe

   localparam int FRAMES_PER_BLOCK    = 192;
   localparam int SLOTS_PER_SUBFRAME  = 32;
   localparam int HALFCELLS_PER_FRAME = 2 * 2 * SLOTS_PER_SUBFRAME;

   // Slot positions inside a subframe
   localparam int SLOT_AUDIO_LSB = 4;
   localparam int SLOT_AUDIO_MSB = 27;
   localparam int SLOT_V         = 28;
   localparam int SLOT_U         = 29;
   localparam int SLOT_C         = 30;
   localparam int SLOT_P         = 31;

   // Channel-status bit positions
   localparam int CS_BIT_COPY   = 2;
   localparam int CS_BIT_FS_LSB = 24;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Channel-status bit for a given frame of the block; everything not listed is 0.
   function automatic logic cs_bit(input logic [7:0] frame,
                                   input logic [3:0] fs,
                                   input logic       copy);
      logic b;
      b = 1'b0;
      if (frame == 8'(CS_BIT_COPY))
         b = copy;
      else if (frame >= 8'(CS_BIT_FS_LSB) && frame <= 8'(CS_BIT_FS_LSB + 3))
         b = fs[2'(frame - 8'(CS_BIT_FS_LSB))];
      return b;
   endfunction

endpackage

// File: rtl/spdif_bmc.sv
// Biphase-mark line coder: owns the output level register and updates it once per half-cell.
// Latency: 1 clk from half-cell control inputs to level.
// Backpressure: none; driven every clock by the framer.
//
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   run        0 forces the line low
//   load       first clock of a half-cell; level only changes here
//   bit_val    data bit of the current slot (ignored during preambles)
//   hc_phase   half-cell index low bits: [2:0] indexes the preamble, [0] is the slot half
//   pre_sel    current slot is part of the preamble
//   pre_pat    preamble pattern, MSB first
//   level      encoded line level
module spdif_bmc
   import spdif_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       load,
   input  logic       bit_val,
   input  logic [2:0] hc_phase,
   input  logic       pre_sel,
   input  logic [7:0] pre_pat,
   output logic       level
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 1'b0;
      end else if (!run) begin
         level <= 1'b0;
      end else if (load) begin
         if (pre_sel)
            level <= pre_pat[3'd7 - hc_phase];  // preambles are sent verbatim
         else if (!hc_phase[0])
            level <= ~level;                     // every slot starts with a transition
         else if (bit_val)
            level <= ~level;                     // a 1 adds a mid-slot transition
      end
   end

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF consumer transmitter: frames 24-bit L/R samples into 192-frame blocks and BMC encodes them.
// Latency: first preamble half-cell 1 clk after entering RUN; samples go out in the frame after capture.
// Backpressure: none; a missing sample repeats the previous one and pulses frame_underrun.
//
// Optional feature macro: SPDIF_UNDERRUN_VALIDITY_EN -- when defined, frames carrying repeated
// samples send V=1 in both subframes (parity includes it). Undefined: V is always 0.
//
// Ports:
//   clk, rst                clock / asynchronous active-high reset
//   enable                  transmitter enable; dropping it returns to IDLE at once
//   next_sample             one-cycle sample strobe, qualifies left_data/right_data
//   left_data, right_data   signed 24-bit samples
//   spdif_out               registered BMC line output
//   block_start             pulse on the first clock of frame 0
//   frame_underrun          pulse on the first clock of a frame that repeats old samples
module spdif_tx
   import spdif_pkg::*;
#(
   parameter int         CLKS_PER_HALFCELL = 4,
   parameter logic [3:0] CS_FS             = 4'b0010,
   parameter logic       CS_COPY           = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        next_sample,
   input  logic [23:0] left_data,
   input  logic [23:0] right_data,
   output logic        spdif_out,
   output logic        block_start,
   output logic        frame_underrun
);

   localparam int             DIV_W     = (CLKS_PER_HALFCELL > 1) ? $clog2(CLKS_PER_HALFCELL) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_HALFCELL - 1);
   localparam logic [6:0]     HC_MAX    = 7'(HALFCELLS_PER_FRAME - 1);
   localparam logic [7:0]     FRAME_MAX = 8'(FRAMES_PER_BLOCK - 1);

`ifdef SPDIF_UNDERRUN_VALIDITY_EN
   localparam logic VALIDITY_ON = 1'b1;
`else
   localparam logic VALIDITY_ON = 1'b0;
`endif

   state_t             state, state_nxt;
   logic               run_active, start_evt;
   logic [DIV_W-1:0]   div;
   logic [6:0]         hc;
   logic [7:0]         frame_idx;
   logic [23:0]        frame_l, frame_r;
   logic [23:0]        pend_l, pend_r;
   logic               pend_vld;
   logic               rpt;          // current frame carries repeated samples
   logic               frame_end;
   logic [4:0]         slot;
   logic [23:0]        smp;
   logic               v_bit, c_bit, par, slot_bit;
   logic [7:0]         pre_pat;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (enable && next_sample) state_nxt = RUN;
         RUN:  if (!enable)               state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   always_comb begin
      run_active = (state == RUN) && enable;
      start_evt  = (state == IDLE) && enable && next_sample;
   end

   assign frame_end = run_active && (hc == HC_MAX) && (div == DIV_MAX);

   // ---------------- Counters ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div       <= '0;
         hc        <= '0;
         frame_idx <= '0;
      end else if (!run_active) begin
         div       <= '0;
         hc        <= '0;
         frame_idx <= '0;
      end else if (div == DIV_MAX) begin
         div <= '0;
         hc  <= hc + 7'd1;                 // 7-bit wrap is the frame wrap
         if (hc == HC_MAX)
            frame_idx <= (frame_idx == FRAME_MAX) ? 8'd0 : frame_idx + 8'd1;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   // ---------------- Sample capture ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_l        <= '0;
         frame_r        <= '0;
         pend_l         <= '0;
         pend_r         <= '0;
         pend_vld       <= 1'b0;
         rpt            <= 1'b0;
         block_start    <= 1'b0;
         frame_underrun <= 1'b0;
      end else begin
         block_start    <= 1'b0;
         frame_underrun <= 1'b0;
         if (start_evt) begin
            frame_l     <= left_data;
            frame_r     <= right_data;
            pend_vld    <= 1'b0;
            rpt         <= 1'b0;
            block_start <= 1'b1;
         end else if (!run_active) begin
            pend_vld <= 1'b0;
            rpt      <= 1'b0;
         end else if (frame_end) begin
            block_start <= (frame_idx == FRAME_MAX);
            if (next_sample) begin
               // A strobe on the boundary clock is newer than anything pending
               frame_l  <= left_data;
               frame_r  <= right_data;
               pend_vld <= 1'b0;
               rpt      <= 1'b0;
            end else if (pend_vld) begin
               frame_l  <= pend_l;
               frame_r  <= pend_r;
               pend_vld <= 1'b0;
               rpt      <= 1'b0;
            end else begin
               rpt            <= 1'b1;
               frame_underrun <= 1'b1;
            end
         end else if (next_sample) begin
            pend_l   <= left_data;
            pend_r   <= right_data;
            pend_vld <= 1'b1;
         end
      end
   end

   // ---------------- Subframe slot contents ----------------
   assign slot  = hc[5:1];
   assign smp   = hc[6] ? frame_r : frame_l;
   assign v_bit = rpt & VALIDITY_ON;
   assign c_bit = cs_bit(frame_idx, CS_FS, CS_COPY);
   assign par   = (^smp) ^ v_bit ^ c_bit;   // U is always 0

   always_comb begin
      slot_bit = 1'b0;
      if (slot >= 5'(SLOT_AUDIO_LSB) && slot <= 5'(SLOT_AUDIO_MSB))
         slot_bit = smp[slot - 5'(SLOT_AUDIO_LSB)];
      else if (slot == 5'(SLOT_V))
         slot_bit = v_bit;
      else if (slot == 5'(SLOT_C))
         slot_bit = c_bit;
      else if (slot == 5'(SLOT_P))
         slot_bit = par;
   end

   assign pre_pat = hc[6] ? PRE_W : ((frame_idx == 8'd0) ? PRE_B : PRE_M);

   spdif_bmc u_bmc (
      .clk      (clk),
      .rst      (rst),
      .run      (run_active),
      .load     (run_active && (div == '0)),
      .bit_val  (slot_bit),
      .hc_phase (hc[2:0]),
      .pre_sel  (hc[5:3] == 3'd0),
      .pre_pat  (pre_pat),
      .level    (spdif_out)
   );

endmodule

// File: tb/tb_spdif_tx.sv
// Directed bench for spdif_tx with a short half-cell (2 clks) so a full block fits in the run.
// Latency: n/a.
// Backpressure: n/a.
module tb_spdif_tx;

   localparam int C = 2;           // clks per half-cell in this bench
   localparam int F = 128 * C;     // clks per frame

`ifdef SPDIF_UNDERRUN_VALIDITY_EN
   localparam logic VEXP = 1'b1;
`else
   localparam logic VEXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        next_sample;
   logic [23:0] left_data, right_data;
   logic        spdif_out, block_start, frame_underrun;

   int passes = 0;
   int total  = 0;
   int fidx   = 0;

   always #5 clk = ~clk;

   spdif_tx #(.CLKS_PER_HALFCELL(C)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .next_sample    (next_sample),
      .left_data      (left_data),
      .right_data     (right_data),
      .spdif_out      (spdif_out),
      .block_start    (block_start),
      .frame_underrun (frame_underrun)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      assert (got === exp) passes++;
      else $error("FAIL %s frame_idx=%0d got=%h exp=%h", tag, fidx, got, exp);
   endtask

   function automatic logic [23:0] ld(input int f);
      return 24'h000001 + 24'(f << 4);
   endfunction

   function automatic logic [23:0] rd(input int f);
      return 24'h800000 | 24'(f);
   endfunction

   // Reference encoder: half-cell 0 of the frame lands in bit 127.
   function automatic logic [127:0] exp_frame(input logic [23:0] l, input logic [23:0] r,
                                              input int fi, input logic v);
      logic [127:0] f;
      logic [7:0]   pre;
      logic [27:0]  bits;
      logic         lvl;
      int           h;
      f = '0;
      for (int sub = 0; sub < 2; sub++) begin
         pre        = (sub == 1) ? 8'b11100100 : ((fi == 0) ? 8'b11101000 : 8'b11100010);
         bits[23:0] = (sub == 1) ? r : l;
         bits[24]   = v;
         bits[25]   = 1'b0;
         bits[26]   = (fi == 2) || (fi == 25);
         bits[27]   = ^bits[26:0];
         h = sub * 64;
         for (int i = 0; i < 8; i++) f[127 - (h + i)] = pre[7 - i];
         lvl = 1'b0;
         for (int k = 0; k < 28; k++) begin
            lvl = ~lvl;
            f[127 - (h + 8 + 2 * k)] = lvl;
            if (bits[k]) lvl = ~lvl;
            f[127 - (h + 9 + 2 * k)] = lvl;
         end
      end
      return f;
   endfunction

   // Entered at the negedge right after a frame-start edge; leaves at the next one.
   task automatic run_frame(input int s1, input logic [23:0] l1, input logic [23:0] r1,
                            input int s2, input logic [23:0] l2, input logic [23:0] r2,
                            output logic [127:0] hcs, output logic bs, output logic ur);
      bs = block_start;
      ur = frame_underrun;
      chk("boundary_low", spdif_out, 1'b0);
      hcs = '0;
      for (int c = 0; c < F; c++) begin
         if (c == s1) begin next_sample = 1'b1; left_data = l1; right_data = r1; end
         if (c == s2) begin next_sample = 1'b1; left_data = l2; right_data = r2; end
         @(posedge clk);
         @(negedge clk);
         next_sample = 1'b0;
         if (c % C == 0) hcs[127 - c / C] = spdif_out;
      end
   endtask

   task automatic check_frame(input string tag, input logic [23:0] el, input logic [23:0] er,
                              input logic ev, input logic ebs, input logic eur,
                              input int s1, input logic [23:0] l1, input logic [23:0] r1,
                              input int s2, input logic [23:0] l2, input logic [23:0] r2);
      logic [127:0] hcs;
      logic         bs, ur;
      run_frame(s1, l1, r1, s2, l2, r2, hcs, bs, ur);
      chk({tag, "_frame"}, hcs, exp_frame(el, er, fidx, ev));
      chk({tag, "_block_start"}, bs, ebs);
      chk({tag, "_underrun"}, ur, eur);
      chk({tag, "_mid_boundary"}, hcs[64], 1'b0);
      fidx = (fidx + 1) % 192;
   endtask

   task automatic start(input logic [23:0] l, input logic [23:0] r);
      enable      = 1'b1;
      next_sample = 1'b1;
      left_data   = l;
      right_data  = r;
      @(posedge clk);
      @(negedge clk);
      next_sample = 1'b0;
      fidx = 0;
   endtask

   initial begin
      logic [127:0] hcs;
      logic         bs, ur, any;

      rst = 1'b1; enable = 1'b0; next_sample = 1'b0; left_data = '0; right_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_spdif_out", spdif_out, 1'b0);
      chk("rst_block_start", block_start, 1'b0);
      chk("rst_underrun", frame_underrun, 1'b0);
      rst = 1'b0;
      enable = 1'b1;
      any = 1'b0;
      repeat (8) begin @(negedge clk); any |= spdif_out; end
      chk("idle_low", any, 1'b0);

      // Frame 0 with hand-derived half-cell checks
      start(ld(0), rd(0));
      run_frame(F - 1, ld(1), rd(1), -1, '0, '0, hcs, bs, ur);
      chk("f0_preamble_B", hcs[127:120], 8'b11101000);
      chk("f0_left_slot4", hcs[119:118], 2'b10);
      chk("f0_left_parity", hcs[65:64], 2'b10);
      chk("f0_preamble_W", hcs[63:56], 8'b11100100);
      chk("f0_right_msb", hcs[9:8], 2'b01);
      chk("f0_right_parity", hcs[1:0], 2'b10);
      chk("f0_frame", hcs, exp_frame(ld(0), rd(0), 0, 1'b0));
      chk("f0_block_start", bs, 1'b1);
      chk("f0_underrun", ur, 1'b0);
      fidx = 1;

      // Rest of the block plus the first frame of the next one, strobes on the boundary clock
      for (int f = 1; f <= 192; f++)
         check_frame("blk", ld(f), rd(f), 1'b0, (f == 192), 1'b0,
                     F - 1, ld(f + 1), rd(f + 1), -1, '0, '0);

      // No strobe: next frame repeats, then two mid-frame strobes (newest wins)
      check_frame("nostrobe", ld(193), rd(193), 1'b0, 1'b0, 1'b0, -1, '0, '0, -1, '0, '0);
      check_frame("repeat", ld(193), rd(193), VEXP, 1'b0, 1'b1,
                  60, 24'h111111, 24'h222222, 180, 24'h5A5A5A, 24'hA5A5A5);
      check_frame("newest", 24'h5A5A5A, 24'hA5A5A5, 1'b0, 1'b0, 1'b0,
                  F - 1, 24'h7FFFFF, 24'h800001, -1, '0, '0);
      check_frame("bypass", 24'h7FFFFF, 24'h800001, 1'b0, 1'b0, 1'b0, -1, '0, '0, -1, '0, '0);
      check_frame("repeat2", 24'h7FFFFF, 24'h800001, VEXP, 1'b0, 1'b1,
                  F - 1, 24'h00F00D, 24'hC0FFEE, -1, '0, '0);
      check_frame("recover", 24'h00F00D, 24'hC0FFEE, 1'b0, 1'b0, 1'b0,
                  30, 24'h3C3C3C, 24'hC3C3C3, -1, '0, '0);

      // Disable mid-subframe with a sample pending
      for (int c = 0; c < 40; c++) begin
         if (c == 10) begin next_sample = 1'b1; left_data = 24'hDEAD00; right_data = 24'h00BEEF; end
         @(posedge clk);
         @(negedge clk);
         next_sample = 1'b0;
      end
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("disable_out", spdif_out, 1'b0);
      any = 1'b0;
      repeat (20) begin @(posedge clk); @(negedge clk); any |= spdif_out; end
      chk("disable_hold", any, 1'b0);

      // Restart: B preamble at frame 0; pending was dropped so frame 1 underruns
      start(24'h654321, 24'h123456);
      check_frame("restart", 24'h654321, 24'h123456, 1'b0, 1'b1, 1'b0, -1, '0, '0, -1, '0, '0);
      chk("restart_underrun", frame_underrun, 1'b1);

      // Asynchronous reset between edges clears outputs at once
      #2 rst = 1'b1;
      #1 chk("arst_underrun", frame_underrun, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      start(24'h000100, 24'h000200);
      chk("pre_arst_block_start", block_start, 1'b1);
      #2 rst = 1'b1;
      #1 chk("arst_block_start", block_start, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      start(24'h000100, 24'h000200);
      @(posedge clk);
      @(negedge clk);
      chk("pre_arst_level", spdif_out, 1'b1);
      #2 rst = 1'b1;
      #1 chk("arst_spdif_out", spdif_out, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      any = 1'b0;
      repeat (10) begin @(negedge clk); any |= spdif_out; end
      chk("post_arst_idle", any, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/spdif_tx.md
Name: spdif_tx

Overview:
- S/PDIF (IEC 60958 consumer) transmitter fed by the audio block's sample strobe and 24-bit left/right mix.
- Sits beside the I2S DAC interface as a second consumer of the mixed output and drives one optical/coax output pin.
- Builds a 192-frame channel-status block and biphase-mark encodes it, keeping frame timing locked to next_sample.

Parameters:
- CLKS_PER_HALFCELL, 4, clk cycles per BMC half-cell; frame = 128 half-cells = 512 clks at default, matching the next_sample period.
- CS_FS, 4'b0010, channel-status bits 24..27 (index 0 = bit 24); default encodes 48 kHz.
- CS_COPY, 1'b1, channel-status bit 2 (copy permitted).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  transmitter enable
- next_sample  in  1  one-cycle sample strobe from the audio timing
- left_data  in  24  signed left sample, valid while next_sample is high
- right_data  in  24  signed right sample, valid while next_sample is high
- spdif_out  out  1  BMC-encoded serial output
- block_start  out  1  one-cycle pulse at the start of frame 0 of each block
- frame_underrun  out  1  one-cycle pulse when a frame starts without a fresh sample

Behaviour:
- Reset:
  - state IDLE; all counters 0.
  - spdif_out=0, block_start=0, frame_underrun=0.
  - pending regs 0, pending flag clear.
- IDLE:
  - spdif_out held 0.
  - On next_sample with enable=1: load left_data/right_data directly into the frame regs.
  - Next cycle: RUN, position 0, frame index 0.
- RUN counters:
  - div counts 0..CLKS_PER_HALFCELL-1.
  - hc (7 bits) counts 0..127 and advances when div wraps; hc[6]=0 is the left subframe, hc[6]=1 the right.
  - frame index counts 0..191 and advances when hc wraps.
- Last clock of a frame (hc=127 and div=max), frame regs load with this priority:
  - next_sample high that cycle: bypass, take left_data/right_data directly.
  - Else pending flag set: take pending regs, clear flag.
  - Else: keep previous samples and pulse frame_underrun next cycle.
- next_sample at any other RUN cycle: capture into pending regs and set the flag; a second strobe before the load overwrites (newest wins).
- Subframe of 32 slots, 2 half-cells each:
  - Slots 0-3: preamble. Frame 0 left = B (11101000). Other left = M (11100010). Right = W (11100100). Half-cells are emitted verbatim.
  - Slots 4-27: audio bits, LSB first.
  - Slot 28: V=0.
  - Slot 29: U=0.
  - Slot 30: C = channel-status bit [frame index]; the same bit goes in both subframes.
  - Slot 31: P = XOR of slots 4..30 (even parity).
- BMC for slots 4-31:
  - Toggle at the start of each slot.
  - Toggle again mid-slot if the bit is 1.
  - Even parity guarantees spdif_out=0 at every subframe boundary, so preambles never need inversion.
- Channel status:
  - Bit 2 = CS_COPY.
  - Bits 24..27 = CS_FS.
  - All other bits 0 (consumer, PCM, no emphasis, category general).
- block_start pulses on the first clock of frame 0.
- enable falling in RUN:
  - Return to IDLE immediately; spdif_out=0.
  - Clear counters and pending flag.
  - Next start begins with a B preamble.
- Output timing: spdif_out is registered; the first preamble half-cell appears 1 cycle after entering RUN.

Optional Feature:
- Macro SPDIF_UNDERRUN_VALIDITY_EN.
- Defined: frames carrying repeated (underrun) samples transmit V=1 in both subframes, and parity includes it.
- Undefined: V=0 always; frame_underrun still pulses.

Decomposition:
- Shared package spdif_pkg:
  - preamble constants B/M/W (8-bit half-cell patterns).
  - FRAMES_PER_BLOCK=192, SLOTS_PER_SUBFRAME=32.
  - channel-status bit-position constants.
  - state encoding IDLE/RUN.
- One sub-module spdif_bmc:
  - inputs: slot bit, half-cell phase, preamble-select, preamble pattern.
  - holds the output level register.
- Framing and counters stay in spdif_tx.

Test Plan:
- Reset then enable=1 with next_sample every 512 clks, left=24'h000001, right=24'h800000 -> B preamble, left slots 4-27 = 1 then 23 zeros, P=1; W preamble, right MSB slot 27=1; no frame_underrun.
- Run 193 frames -> block_start pulses exactly at frames 0 and 192; preamble B only on those frames; C slot is 1 at frames 2, 25 and 0 elsewhere with default CS_FS.
- Stop next_sample after frame 5 -> frame_underrun pulses at frame 6; samples repeat; V=1 only when SPDIF_UNDERRUN_VALIDITY_EN is defined.
- Two strobes mid-frame (values A then B) -> next frame carries B.
- Strobe coincident with the frame-end clock -> bypass data is used, no underrun.
- Deassert enable mid-subframe, reassert, strobe -> spdif_out=0 while disabled; restart begins with B at frame index 0.
- Assert rst mid-frame -> all outputs 0 on the same edge (asynchronous); spdif_out low at every subframe boundary throughout all tests.
